// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, NOP encoding, default instruction
// memory size, fetch-stage state type and a fetch address check.
package cpu_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam int DEF_IMEM_BYTES = 256;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } if_state_t;

   // A fetch address is usable when it is word aligned and leaves room
   // for a full word below the end of instruction memory.
   function automatic logic fetch_addr_ok(input logic [WORD_W-1:0] addr,
                                          input logic [WORD_W-1:0] last_addr);
      return (addr[1:0] == 2'b00) && (addr <= last_addr);
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between two stages. Bubble wins over load; with
// neither asserted the contents hold. A bubble clears the instruction and
// valid flag but keeps the pc fields so they still name the last slot.
module ifid_reg
   import cpu_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         bubble,
   input  logic [W-1:0] instr_d,
   input  logic [W-1:0] pc_d,
   input  logic [W-1:0] pc4_d,
   output logic [W-1:0] instr_q,
   output logic [W-1:0] pc_q,
   output logic [W-1:0] pc4_q,
   output logic         valid_q
);

   // Stage register: bubble, load or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         pc_q    <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (bubble) begin
         instr_q <= W'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (load) begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction RAM,
// captures the returned word into IF/ID, and halts with a sticky fault on
// a misaligned or out-of-range fetch target.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = DEF_IMEM_BYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        flush,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        fault,
   output logic [31:0] fault_pc
);

   // Highest address from which a whole word can still be fetched.
   localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

   if_state_t   state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        fault_reg, fault_next;
   logic [31:0] fault_pc_reg, fault_pc_next;
   logic [31:0] pc_seq;
   logic        ifid_load, ifid_bubble;

   assign pc_seq = pc_reg + 32'd4;

   // State, PC and fault capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= BOOT;
         pc_reg       <= RESET_PC;
         fault_reg    <= 1'b0;
         fault_pc_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         fault_reg    <= fault_next;
         fault_pc_reg <= fault_pc_next;
      end
   end

   // Next-state, next-PC and IF/ID control; branch beats flush beats stall.
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      fault_next    = fault_reg;
      fault_pc_next = fault_pc_reg;
      ifid_load     = 1'b0;
      ifid_bubble   = 1'b0;
      case (state_reg)
         BOOT: begin
            ifid_bubble = 1'b1;
            state_next  = FETCH;
         end
         FETCH: begin
            if (branch_taken) begin
               ifid_bubble = 1'b1;
               if (fetch_addr_ok(branch_target, LAST_ADDR)) begin
                  pc_next = branch_target;
               end else begin
                  state_next    = FAULT;
                  fault_next    = 1'b1;
                  fault_pc_next = branch_target;
               end
            end else if (flush || !stall) begin
               // A flush squashes the captured word but the PC still
               // advances unless the hazard unit is holding it.
               ifid_bubble = flush;
               ifid_load   = !flush;
               if (!stall) begin
                  if (pc_seq > LAST_ADDR) begin
                     // Word at pc is still delivered; the overrun address
                     // is reported and the PC stays on the last word.
                     state_next    = FAULT;
                     fault_next    = 1'b1;
                     fault_pc_next = pc_seq;
                  end else begin
                     pc_next = pc_seq;
                  end
               end
            end
         end
         FAULT: begin
            ifid_bubble = 1'b1;
         end
         default: begin
            ifid_bubble = 1'b1;
            state_next  = FAULT;
         end
      endcase
   end

   // RAM is only read in FETCH when not stalled; rst_n gates it directly
   // so the enable falls the moment reset is asserted.
   assign imem_en   = rst_n && (state_reg == FETCH) && !stall;
   assign imem_addr = {pc_reg[31:2], 2'b00};
   assign fault     = fault_reg;
   assign fault_pc  = fault_pc_reg;

   ifid_reg #(.W(WORD_W)) u_ifid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ifid_load),
      .bubble  (ifid_bubble),
      .instr_d (imem_data),
      .pc_d    (pc_reg),
      .pc4_d   (pc_seq),
      .instr_q (ifid_instr),
      .pc_q    (ifid_pc),
      .pc4_q   (ifid_pc4),
      .valid_q (ifid_valid)
   );

endmodule
